// File: rtl/usb_rx_pkg.sv
// Shared types for the USB full-speed receive path: FSM states and the
// 2-bit {d_plus, d_minus} line-state encodings.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RECV      = 3'd1,
        EOP1      = 3'd2,
        EOP2      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    // Number of consecutive decoded ones after which a stuffed bit follows.
    localparam int STUFF_LIMIT = 6;

endpackage

// File: rtl/rx_bit_timer.sv
// Edge-reloaded mod-OVERSAMPLE bit timer; sample_pt marks the mid-bit cycle
// of the registered count.
module rx_bit_timer #(
    parameter  int OVERSAMPLE = 8,
    localparam int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic clk,
    input  logic rst,
    input  logic line_edge,
    output logic sample_pt
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (line_edge) begin
            count <= '0;
        end else if (count == CNT_W'(OVERSAMPLE - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Decided from the registered count, so an edge in this cycle still samples.
    assign sample_pt = (count == CNT_W'(OVERSAMPLE / 2));

endmodule

// File: rtl/usb_rx_sample_ctrl.sv
// USB full-speed RX bit timing, NRZI decode and SOP/EOP/error line-state FSM.
// Bit unstuffing is compiled in when USB_RX_UNSTUFF_EN is defined.
module usb_rx_sample_ctrl
    import usb_rx_pkg::*;
#(
    parameter  int OVERSAMPLE = 8,
    localparam int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    output logic       shift_enable,
    output logic       d_orig,
    output logic       rcving,
    output logic       eop,
    output logic       rx_error,
    output logic       stuff_err,
    output logic [2:0] state
);

    rx_state_t        st;
    logic             dp_q;
    logic             prev_lvl;
    logic             line_edge;
    logic             sample_pt;
    logic             decoded;
    logic [1:0]       ls;
    logic [CNT_W-1:0] j_cnt;

    assign ls        = {d_plus_sync, d_minus_sync};
    assign line_edge = (d_plus_sync != dp_q);
    assign decoded   = (d_plus_sync == prev_lvl);
    assign state     = st;

`ifdef USB_RX_UNSTUFF_EN
    logic [2:0] ones_cnt;
`else
    assign stuff_err = 1'b0;
`endif

    rx_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .line_edge(line_edge),
        .sample_pt(sample_pt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= IDLE;
            dp_q         <= 1'b1;
            prev_lvl     <= 1'b1;
            j_cnt        <= '0;
            shift_enable <= 1'b0;
            d_orig       <= 1'b0;
            rcving       <= 1'b0;
            eop          <= 1'b0;
            rx_error     <= 1'b0;
`ifdef USB_RX_UNSTUFF_EN
            ones_cnt     <= '0;
            stuff_err    <= 1'b0;
`endif
        end else begin
            dp_q         <= d_plus_sync;
            shift_enable <= 1'b0;
            d_orig       <= 1'b0;
            eop          <= 1'b0;
            rx_error     <= 1'b0;
`ifdef USB_RX_UNSTUFF_EN
            stuff_err    <= 1'b0;
`endif
            if (st != WAIT_IDLE) j_cnt <= '0;

            case (st)
                IDLE: begin
                    // J->K transition starts the packet; the edge also reloads the timer.
                    if (line_edge && ls == LS_K) begin
                        st       <= RECV;
                        rcving   <= 1'b1;
                        prev_lvl <= 1'b1;
`ifdef USB_RX_UNSTUFF_EN
                        ones_cnt <= '0;
`endif
                    end
                end
                RECV: begin
                    if (sample_pt) begin
                        if (ls == LS_SE0) begin
                            st <= EOP1;
`ifdef USB_RX_UNSTUFF_EN
                            ones_cnt <= '0;
`endif
                        end else if (ls == LS_SE1) begin
                            rx_error <= 1'b1;
                            rcving   <= 1'b0;
                            st       <= WAIT_IDLE;
                        end else begin
                            prev_lvl <= d_plus_sync;
`ifdef USB_RX_UNSTUFF_EN
                            if (ones_cnt == 3'(STUFF_LIMIT)) begin
                                // Stuffed bit: must be a transition, never forwarded.
                                ones_cnt <= '0;
                                if (decoded) begin
                                    stuff_err <= 1'b1;
                                    rx_error  <= 1'b1;
                                    rcving    <= 1'b0;
                                    st        <= WAIT_IDLE;
                                end
                            end else begin
                                shift_enable <= 1'b1;
                                d_orig       <= decoded;
                                ones_cnt     <= decoded ? ones_cnt + 3'd1 : 3'd0;
                            end
`else
                            shift_enable <= 1'b1;
                            d_orig       <= decoded;
`endif
                        end
                    end
                end
                EOP1: begin
                    if (sample_pt) begin
                        if (ls == LS_SE0) begin
                            st <= EOP2;
                        end else begin
                            rx_error <= 1'b1;
                            rcving   <= 1'b0;
                            st       <= WAIT_IDLE;
                        end
                    end
                end
                EOP2: begin
                    if (sample_pt) begin
                        if (ls == LS_J) begin
                            eop    <= 1'b1;
                            rcving <= 1'b0;
                            st     <= IDLE;
                        end else begin
                            rx_error <= 1'b1;
                            rcving   <= 1'b0;
                            st       <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    rcving <= 1'b0;
                    if (ls == LS_J) begin
                        if (j_cnt == CNT_W'(OVERSAMPLE - 1)) begin
                            j_cnt <= '0;
                            st    <= IDLE;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                    end else begin
                        j_cnt <= '0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_sample_ctrl.sv
// Directed bench for usb_rx_sample_ctrl: NRZI packets, jittered bit lengths,
// EOP, SE1 error, stuffing (both builds) and mid-packet reset.
module tb_usb_rx_sample_ctrl;
    import usb_rx_pkg::*;

    localparam int OVERSAMPLE = 8;
    localparam int CLK_P      = 10;

    logic       clk;
    logic       rst;
    logic       d_plus_sync;
    logic       d_minus_sync;
    logic       shift_enable;
    logic       d_orig;
    logic       rcving;
    logic       eop;
    logic       rx_error;
    logic       stuff_err;
    logic [2:0] state;

    usb_rx_sample_ctrl #(.OVERSAMPLE(OVERSAMPLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .d_plus_sync (d_plus_sync),
        .d_minus_sync(d_minus_sync),
        .shift_enable(shift_enable),
        .d_orig      (d_orig),
        .rcving      (rcving),
        .eop         (eop),
        .rx_error    (rx_error),
        .stuff_err   (stuff_err),
        .state       (state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    int   checks    = 0;
    int   failures  = 0;
    int   eop_cnt   = 0;
    int   err_cnt   = 0;
    int   stuff_cnt = 0;
    logic cur_lvl   = 1'b1;
    logic rcv_prev  = 1'b0;
    time  rise_t    = 0;
    time  strobe_t[$];
    logic [0:0] exp_q[$];

`ifdef USB_RX_UNSTUFF_EN
    localparam logic STUFF_ON = 1'b1;
`else
    localparam logic STUFF_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Driver tasks: inputs change on the falling edge.
    task automatic drive_ls(input logic [1:0] l, input int n);
        repeat (n) begin
            @(negedge clk);
            {d_plus_sync, d_minus_sync} = l;
        end
    endtask

    task automatic send_nrzi(input logic b, input int n, input logic expect_strobe);
        if (!b) cur_lvl = ~cur_lvl;
        if (expect_strobe) exp_q.push_back(b);
        drive_ls(cur_lvl ? LS_J : LS_K, n);
    endtask

    task automatic send_sync();
        cur_lvl = 1'b0;
        exp_q.push_back(1'b0);
        drive_ls(LS_K, 1);
        check("rcving_before_sop", rcving, 1'b0);
        drive_ls(LS_K, 1);
        check("rcving_rise", rcving, 1'b1);
        drive_ls(LS_K, OVERSAMPLE - 2);
        for (int i = 0; i < 6; i++) send_nrzi(1'b0, OVERSAMPLE, 1'b1);
        send_nrzi(1'b1, OVERSAMPLE, 1'b1);
    endtask

    task automatic send_eop();
        drive_ls(LS_SE0, 2 * OVERSAMPLE);
        drive_ls(LS_J, OVERSAMPLE);
        cur_lvl = 1'b1;
    endtask

    task automatic clear_counts();
        eop_cnt   = 0;
        err_cnt   = 0;
        stuff_cnt = 0;
        strobe_t.delete();
    endtask

    // Scoreboard / monitor, sampled 2 time units after the active edge.
    always @(posedge clk) begin
        #2;
        if (rcving && !rcv_prev) rise_t = $time;
        if (shift_enable) begin
            strobe_t.push_back($time);
            if (exp_q.size() == 0) check("unexpected_strobe", shift_enable, 1'b0);
            else check("d_orig", d_orig, exp_q.pop_front());
        end
        if (eop) begin
            eop_cnt++;
            check("rcving_fall_at_eop", rcving, 1'b0);
            check("rcving_before_eop", rcv_prev, 1'b1);
        end
        if (rx_error) err_cnt++;
        if (stuff_err) stuff_cnt++;
        rcv_prev = rcving;
    end

    localparam logic pay2 [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic pay3 [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        {d_plus_sync, d_minus_sync} = LS_J;
        repeat (3) @(negedge clk);
        check("rst_shift_enable", shift_enable, 1'b0);
        check("rst_rcving", rcving, 1'b0);
        check("rst_state", state, IDLE);
        rst = 1'b0;

        // 1: idle J
        clear_counts();
        drive_ls(LS_J, 50);
        check("idle_strobes", strobe_t.size(), 0);
        check("idle_rcving", rcving, 1'b0);
        check("idle_pulses", eop_cnt + err_cnt + stuff_cnt, 0);

        // 2 + 4: SYNC, payload, EOP at nominal bit length
        clear_counts();
        send_sync();
        for (int i = 0; i < 8; i++) send_nrzi(pay2[i], OVERSAMPLE, 1'b1);
        send_eop();
        drive_ls(LS_J, 4);
        check("pkt_strobes", strobe_t.size(), 16);
        if (strobe_t.size() >= 8) begin
            check("first_strobe_latency", strobe_t[0] - rise_t, 5 * CLK_P);
            check("strobe_spacing_edge", strobe_t[1] - strobe_t[0], OVERSAMPLE * CLK_P);
            check("strobe_spacing_noedge", strobe_t[7] - strobe_t[6], OVERSAMPLE * CLK_P);
        end
        check("pkt_missing", exp_q.size(), 0);
        check("pkt_eop", eop_cnt, 1);
        check("pkt_err", err_cnt, 0);
        check("pkt_state_idle", state, IDLE);

        // 3: bit lengths alternating 7 and 9
        clear_counts();
        send_sync();
        for (int i = 0; i < 8; i++) send_nrzi(pay3[i], (i % 2 == 0) ? 7 : 9, 1'b1);
        send_eop();
        drive_ls(LS_J, 4);
        check("jit_strobes", strobe_t.size(), 16);
        check("jit_missing", exp_q.size(), 0);
        check("jit_eop", eop_cnt, 1);

        // 5: SE1 mid-packet
        clear_counts();
        send_sync();
        send_nrzi(1'b0, OVERSAMPLE, 1'b1);
        send_nrzi(1'b1, OVERSAMPLE, 1'b1);
        drive_ls(LS_SE1, OVERSAMPLE);
        check("se1_err", err_cnt, 1);
        check("se1_strobes", strobe_t.size(), 10);
        check("se1_state_wait", state, WAIT_IDLE);
        drive_ls(LS_J, OVERSAMPLE);
        check("se1_still_wait", state, WAIT_IDLE);
        check("se1_rcving", rcving, 1'b0);
        drive_ls(LS_J, 1);
        check("se1_state_idle", state, IDLE);
        cur_lvl = 1'b1;
        drive_ls(LS_J, 4);
        check("se1_eop", eop_cnt, 0);

        // 6a: six ones then a stuffed zero
        clear_counts();
        send_sync();
        send_nrzi(1'b0, OVERSAMPLE, 1'b1);
        for (int i = 0; i < 6; i++) send_nrzi(1'b1, OVERSAMPLE, 1'b1);
        send_nrzi(1'b0, OVERSAMPLE, ~STUFF_ON);
        send_nrzi(1'b0, OVERSAMPLE, 1'b1);
        send_eop();
        drive_ls(LS_J, 4);
        check("stuff_strobes", strobe_t.size(), STUFF_ON ? 16 : 17);
        check("stuff_missing", exp_q.size(), 0);
        check("stuff_eop", eop_cnt, 1);
        check("stuff_no_err", err_cnt, 0);

        // 6b: six ones then a seventh one
        clear_counts();
        send_sync();
        send_nrzi(1'b0, OVERSAMPLE, 1'b1);
        for (int i = 0; i < 6; i++) send_nrzi(1'b1, OVERSAMPLE, 1'b1);
        send_nrzi(1'b1, OVERSAMPLE, ~STUFF_ON);
        send_eop();
        drive_ls(LS_J, OVERSAMPLE + 2);
        check("stufferr_stuff", stuff_cnt, STUFF_ON ? 1 : 0);
        check("stufferr_rx_error", err_cnt, STUFF_ON ? 1 : 0);
        check("stufferr_eop", eop_cnt, STUFF_ON ? 0 : 1);
        check("stufferr_missing", exp_q.size(), 0);
        check("stufferr_state", state, IDLE);

        // 6c: reset mid-packet
        clear_counts();
        send_sync();
        send_nrzi(1'b0, OVERSAMPLE, 1'b1);
        drive_ls(cur_lvl ? LS_J : LS_K, 5);
        check("midrst_rcving_before", rcving, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_shift_enable", shift_enable, 1'b0);
        check("midrst_rcving", rcving, 1'b0);
        check("midrst_pulses", {eop, rx_error, stuff_err, d_orig}, 4'b0000);
        check("midrst_state", state, IDLE);
        {d_plus_sync, d_minus_sync} = LS_J;
        cur_lvl = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_ls(LS_J, 20);
        check("midrst_no_eop_err", eop_cnt + err_cnt, 0);
        check("midrst_idle_rcving", rcving, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
